// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the execute stage.
//   - ALU function codes carried in the decode-to-execute bus.
//   - Divider FSM state type.
//   - Bus widths, packed bus layouts and field offsets, which the decode and
//     memory stages also use.
//   - is_div_fn(): true for the four divide/remainder codes.
package exe_pkg;

    localparam int XLEN      = 32;
    localparam int ID_EXE_W  = 160;
    localparam int EXE_MEM_W = 155;

    // ALU function codes
    localparam logic [4:0] ALU_ADD    = 5'h00;
    localparam logic [4:0] ALU_SUB    = 5'h01;
    localparam logic [4:0] ALU_AND    = 5'h02;
    localparam logic [4:0] ALU_OR     = 5'h03;
    localparam logic [4:0] ALU_XOR    = 5'h04;
    localparam logic [4:0] ALU_SLL    = 5'h05;
    localparam logic [4:0] ALU_SRL    = 5'h06;
    localparam logic [4:0] ALU_SRA    = 5'h07;
    localparam logic [4:0] ALU_SLT    = 5'h08;
    localparam logic [4:0] ALU_SLTU   = 5'h09;
    localparam logic [4:0] ALU_COPY1  = 5'h0A;
    localparam logic [4:0] ALU_COPY2  = 5'h0B;
    localparam logic [4:0] ALU_MUL    = 5'h10;
    localparam logic [4:0] ALU_MULH   = 5'h11;
    localparam logic [4:0] ALU_MULHSU = 5'h12;
    localparam logic [4:0] ALU_MULHU  = 5'h13;
    localparam logic [4:0] ALU_DIV    = 5'h14;
    localparam logic [4:0] ALU_DIVU   = 5'h15;
    localparam logic [4:0] ALU_REM    = 5'h16;
    localparam logic [4:0] ALU_REMU   = 5'h17;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Decode-to-execute bus, MSB first
    typedef struct packed {
        logic [4:0]  alu_fn;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_we;
        logic        mem_re;
        logic [2:0]  wb_sel;
        logic [31:0] pc;
        logic [31:0] rs2_data;
        logic [3:0]  csr_cmd;
        logic [11:0] csr_addr;
    } id_exe_bus_t;

    // Execute-to-memory bus, MSB first
    typedef struct packed {
        logic [31:0] alu_result;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        mem_we;
        logic        mem_re;
        logic [2:0]  wb_sel;
        logic [31:0] pc;
        logic [31:0] wb_mem_data;
        logic [3:0]  csr_cmd;
        logic [11:0] csr_addr;
        logic [31:0] op1_data;
    } exe_mem_bus_t;

    // Field LSB offsets in the decode-to-execute bus
    localparam int ID_ALU_FN_LSB   = 155;
    localparam int ID_OP1_LSB      = 123;
    localparam int ID_OP2_LSB      = 91;
    localparam int ID_RD_LSB       = 86;
    localparam int ID_RD_WEN_BIT   = 85;
    localparam int ID_MEM_WE_BIT   = 84;
    localparam int ID_MEM_RE_BIT   = 83;
    localparam int ID_WB_SEL_LSB   = 80;
    localparam int ID_PC_LSB       = 48;
    localparam int ID_RS2_DATA_LSB = 16;
    localparam int ID_CSR_CMD_LSB  = 12;
    localparam int ID_CSR_ADDR_LSB = 0;

    // Field LSB offsets in the execute-to-memory bus
    localparam int EX_ALU_RESULT_LSB = 123;
    localparam int EX_RD_LSB         = 118;
    localparam int EX_RD_WEN_BIT     = 117;
    localparam int EX_MEM_WE_BIT     = 116;
    localparam int EX_MEM_RE_BIT     = 115;
    localparam int EX_WB_SEL_LSB     = 112;
    localparam int EX_PC_LSB         = 80;
    localparam int EX_WB_MEM_LSB     = 48;
    localparam int EX_CSR_CMD_LSB    = 44;
    localparam int EX_CSR_ADDR_LSB   = 32;
    localparam int EX_OP1_DATA_LSB   = 0;

    // DIV/DIVU/REM/REMU occupy 0x14..0x17
    function automatic logic is_div_fn(input logic [4:0] fn);
        return fn[4:2] == 3'b101;
    endfunction

endpackage

// File: rtl/exe_stage_div_unit.sv
// div_unit: iterative restoring divider for the execute stage. Only built
// when MULDIV_EN is defined.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : a divide/remainder op is held in the stage register
//   signed_op    : DIV/REM (1) vs DIVU/REMU (0)
//   rem_sel      : return remainder (1) or quotient (0)
//   dividend     : op1
//   divisor      : op2
//   flush        : abort the current divide, return to IDLE
//   done         : result is valid this cycle (state DONE)
//   result       : sign-corrected quotient or remainder
// Timing: IDLE (start seen) -> 32 BUSY cycles -> DONE -> IDLE. Divide by zero
// and signed overflow go straight from IDLE to DONE.
`ifdef MULDIV_EN
module div_unit
    import exe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic        rem_sel,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        done,
    output logic [31:0] result
);

    div_state_t  state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] quo_q;       // dividend bits shift out, quotient bits shift in
    logic [31:0] rem_q;
    logic [31:0] dvs_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        rem_sel_q;

    logic        div_zero;
    logic        div_ovf;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] shifted;
    logic [32:0] diff;

    assign div_zero = (divisor == 32'h0);
    assign div_ovf  = signed_op && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
    assign mag_a    = (signed_op && dividend[31]) ? -dividend : dividend;
    assign mag_b    = (signed_op && divisor[31])  ? -divisor  : divisor;

    // One restoring step: shift next dividend bit into the partial remainder
    // and subtract; bit 32 of diff set means the subtraction borrowed.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
        end else begin
            // NOTE: sequential state is written with non-blocking assignments so
            // every register samples the values from before the edge.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_d (no latch).
        state_d = state_q;
        case (state_q)
            DIV_IDLE: if (start) state_d = (div_zero || div_ovf) ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (cnt_q == 5'd31) state_d = DIV_DONE;
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
        if (flush) state_d = DIV_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
        end else if (!flush) begin
            if (state_q == DIV_IDLE && start) begin
                cnt_q     <= '0;
                rem_sel_q <= rem_sel;
                dvs_q     <= mag_b;
                if (div_zero) begin
                    quo_q     <= 32'hFFFF_FFFF;
                    rem_q     <= dividend;
                    neg_quo_q <= 1'b0;
                    neg_rem_q <= 1'b0;
                end else if (div_ovf) begin
                    quo_q     <= 32'h8000_0000;
                    rem_q     <= 32'h0;
                    neg_quo_q <= 1'b0;
                    neg_rem_q <= 1'b0;
                end else begin
                    quo_q     <= mag_a;
                    rem_q     <= 32'h0;
                    neg_quo_q <= signed_op && (dividend[31] ^ divisor[31]);
                    neg_rem_q <= signed_op && dividend[31];
                end
            end else if (state_q == DIV_BUSY) begin
                quo_q <= {quo_q[30:0], ~diff[32]};
                rem_q <= diff[32] ? shifted[31:0] : diff[31:0];
                cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    assign done   = (state_q == DIV_DONE);
    assign result = rem_sel_q ? (neg_rem_q ? -rem_q : rem_q)
                              : (neg_quo_q ? -quo_q : quo_q);

endmodule
`endif

// File: rtl/exe_stage.sv
// exe_stage: execute stage of the five-stage RISC-V pipeline.
//   clk, rst_n      : clock, asynchronous active-low reset
//   id_exe_bus_in   : 160-bit decode-to-execute bus (layout in exe_pkg)
//   flush_in        : kill the instruction being captured or held here
//   stall_out       : upstream holds id_exe_bus_in while high
//   exe_mem_bus_out : 155-bit execute-to-memory bus, zero while stalled
// Build option MULDIV_EN: enables RV32M multiply (combinational) and the
// iterative divider. Without it codes 0x10-0x17 yield 0 and never stall.
module exe_stage
    import exe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ID_EXE_W-1:0]  id_exe_bus_in,
    input  logic                 flush_in,
    output logic                 stall_out,
    output logic [EXE_MEM_W-1:0] exe_mem_bus_out
);

    id_exe_bus_t  bus_r;
    exe_mem_bus_t out_bus;
    logic [31:0]  alu_result;

    // Flush beats stall: a killed instruction becomes an all-zero NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bus_r <= '0;
        else if (flush_in)   bus_r <= '0;
        else if (!stall_out) bus_r <= id_exe_bus_in;
    end

`ifdef MULDIV_EN
    logic        div_op;
    logic        div_done;
    logic [31:0] div_result;
    logic        mul_a_signed;
    logic        mul_b_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;

    // One 64-bit multiplier covers all four variants: operands are sign- or
    // zero-extended per code, and the low 32 bits are the same either way.
    assign mul_a_signed = (bus_r.alu_fn == ALU_MULH) || (bus_r.alu_fn == ALU_MULHSU);
    assign mul_b_signed = (bus_r.alu_fn == ALU_MULH);
    assign mul_a        = {{32{mul_a_signed & bus_r.op1[31]}}, bus_r.op1};
    assign mul_b        = {{32{mul_b_signed & bus_r.op2[31]}}, bus_r.op2};
    assign mul_prod     = mul_a * mul_b;

    assign div_op = is_div_fn(bus_r.alu_fn);

    // Code bit 0 clear = signed, bit 1 set = remainder.
    div_unit u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_op),
        .signed_op (~bus_r.alu_fn[0]),
        .rem_sel   (bus_r.alu_fn[1]),
        .dividend  (bus_r.op1),
        .divisor   (bus_r.op2),
        .flush     (flush_in),
        .done      (div_done),
        .result    (div_result)
    );

    assign stall_out = div_op && !div_done;
`else
    assign stall_out = 1'b0;
`endif

    always_comb begin
        alu_result = 32'h0;
        case (bus_r.alu_fn)
            ALU_ADD:   alu_result = bus_r.op1 + bus_r.op2;
            ALU_SUB:   alu_result = bus_r.op1 - bus_r.op2;
            ALU_AND:   alu_result = bus_r.op1 & bus_r.op2;
            ALU_OR:    alu_result = bus_r.op1 | bus_r.op2;
            ALU_XOR:   alu_result = bus_r.op1 ^ bus_r.op2;
            ALU_SLL:   alu_result = bus_r.op1 << bus_r.op2[4:0];
            ALU_SRL:   alu_result = bus_r.op1 >> bus_r.op2[4:0];
            ALU_SRA:   alu_result = $signed(bus_r.op1) >>> bus_r.op2[4:0];
            ALU_SLT:   alu_result = {31'h0, $signed(bus_r.op1) < $signed(bus_r.op2)};
            ALU_SLTU:  alu_result = {31'h0, bus_r.op1 < bus_r.op2};
            ALU_COPY1: alu_result = bus_r.op1;
            ALU_COPY2: alu_result = bus_r.op2;
`ifdef MULDIV_EN
            ALU_MUL:    alu_result = mul_prod[31:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  alu_result = mul_prod[63:32];
            ALU_DIV,
            ALU_DIVU,
            ALU_REM,
            ALU_REMU:   alu_result = div_result;
`endif
            default:   alu_result = 32'h0;
        endcase
    end

    always_comb begin
        out_bus             = '0;
        out_bus.alu_result  = alu_result;
        out_bus.rd          = bus_r.rd;
        out_bus.rd_wen      = bus_r.rd_wen;
        out_bus.mem_we      = bus_r.mem_we;
        out_bus.mem_re      = bus_r.mem_re;
        out_bus.wb_sel      = bus_r.wb_sel;
        out_bus.pc          = bus_r.pc;
        out_bus.wb_mem_data = bus_r.rs2_data;
        out_bus.csr_cmd     = bus_r.csr_cmd;
        out_bus.csr_addr    = bus_r.csr_addr;
        out_bus.op1_data    = bus_r.op1;
    end

    // Bubbles go downstream while a divide is in flight.
    assign exe_mem_bus_out = stall_out ? '0 : out_bus;

endmodule
